// File: rtl/branch_resolve_pkg.sv
// Branch-resolution helpers shared by the branch_resolve top.
//   op_illegal    : opcode is one of the two unassigned encodings (010/011)
//   resolve_taken : direction from the registered compare flags
package branch_resolve_pkg;

    import pipes::*;

    localparam int unsigned OP_W = 3;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    // Unassigned encodings fall into default and resolve not-taken.
    function automatic logic resolve_taken(input logic [OP_W-1:0] op,
                                           input logic eq,
                                           input logic lt,
                                           input logic ltu);
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQ:  t = eq;
            BR_BNE:  t = !eq;
            BR_BLT:  t = lt;
            BR_BGE:  t = !lt;
            BR_BLTU: t = ltu;
            BR_BGEU: t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/common.sv
// Shared scalar and word types used across pipeline blocks.
//   u1  : single-bit logic
//   u32 : 32-bit logic word
package common;

    typedef logic        u1;
    typedef logic [31:0] u32;

endpackage

// File: rtl/pipes.sv
// Pipeline-wide definitions: branch opcode encoding and default fall-through step.
package pipes;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_t;

    localparam int unsigned PC_STEP_DEF = 4;

endpackage

// File: rtl/branch_resolve_if.sv
// Branch request / resolution bus.
//   master : upstream + downstream side (drives request, out_ready, flush)
//   slave  : branch_resolve side (drives in_ready and the resolved result)
interface branch_resolve_if #(
    parameter int unsigned WIDTH = 64
);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic             pred_taken;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic             mispredict;
    logic [WIDTH-1:0] redirect_pc;
    logic             illegal_op;

    modport master (
        output in_valid, op, rs1, rs2, pc, imm, pred_taken, flush, out_ready,
        input  in_ready, out_valid, taken, mispredict, redirect_pc, illegal_op
    );

    modport slave (
        input  in_valid, op, rs1, rs2, pc, imm, pred_taken, flush, out_ready,
        output in_ready, out_valid, taken, mispredict, redirect_pc, illegal_op
    );

endinterface

// File: rtl/branch_cmp.sv
// Operand comparator for branch resolution.
//   a, b : WIDTH-bit operands
//   eq   : a == b on all bits
//   lt   : a < b as two's-complement
//   ltu  : a < b as unsigned magnitude
module branch_cmp #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve.sv
// Two-stage elastic branch resolver.
//   S1 registers compare flags, op, both candidate PCs and the prediction;
//   S2 registers direction, mispredict, redirect PC and illegal-op flag.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : branch_resolve_if.slave request/result handshake
//   br_count, mispred_count : 32-bit saturating statistics
//                             (only with BRANCH_RESOLVE_STATS_EN defined)
module branch_resolve
    import common::*;
    import pipes::*;
    import branch_resolve_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned PC_STEP = PC_STEP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output u32               br_count,
    output u32               mispred_count
`endif
);

    u1                w_eq;
    u1                w_lt;
    u1                w_ltu;
    u1                w_s2_load;
    u1                w_s1_adv;
    u1                w_in_fire;
    u1                w_taken;
    u1                w_illegal;
    logic [WIDTH-1:0] w_redirect;

    u1                r_s1_valid;
    u1                r_s1_eq;
    u1                r_s1_lt;
    u1                r_s1_ltu;
    logic [OP_W-1:0]  r_s1_op;
    logic [WIDTH-1:0] r_s1_pc_tgt;
    logic [WIDTH-1:0] r_s1_pc_seq;
    u1                r_s1_pred;

    u1                r_s2_valid;
    u1                r_s2_taken;
    u1                r_s2_mispredict;
    logic [WIDTH-1:0] r_s2_redirect;
    u1                r_s2_illegal;

    branch_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a   (bus.rs1),
        .b   (bus.rs2),
        .eq  (w_eq),
        .lt  (w_lt),
        .ltu (w_ltu)
    );

    // Elastic control: S2 loads when empty or drained; S1 moves with S2.
    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = w_s2_load;
    assign bus.in_ready = !r_s1_valid || w_s1_adv;
    assign w_in_fire    = bus.in_valid && bus.in_ready;

    // Stage 1: capture compare flags and both candidate PCs (wrapping adds).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_eq     <= 1'b0;
            r_s1_lt     <= 1'b0;
            r_s1_ltu    <= 1'b0;
            r_s1_op     <= '0;
            r_s1_pc_tgt <= '0;
            r_s1_pc_seq <= '0;
            r_s1_pred   <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_s1_valid <= 1'b0;
            end else if (bus.in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_fire && !bus.flush) begin
                r_s1_eq     <= w_eq;
                r_s1_lt     <= w_lt;
                r_s1_ltu    <= w_ltu;
                r_s1_op     <= bus.op;
                r_s1_pc_tgt <= bus.pc + bus.imm;
                r_s1_pc_seq <= bus.pc + WIDTH'(PC_STEP);
                r_s1_pred   <= bus.pred_taken;
            end
        end
    end

    // Stage 2 resolution logic.
    always_comb begin
        w_taken    = resolve_taken(r_s1_op, r_s1_eq, r_s1_lt, r_s1_ltu);
        w_illegal  = op_illegal(r_s1_op);
        w_redirect = w_taken ? r_s1_pc_tgt : r_s1_pc_seq;
    end

    // Stage 2: result register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid      <= 1'b0;
            r_s2_taken      <= 1'b0;
            r_s2_mispredict <= 1'b0;
            r_s2_redirect   <= '0;
            r_s2_illegal    <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load && r_s1_valid && !bus.flush) begin
                r_s2_taken      <= w_taken;
                r_s2_mispredict <= (w_taken != r_s1_pred);
                r_s2_redirect   <= w_redirect;
                r_s2_illegal    <= w_illegal;
            end
        end
    end

    assign bus.out_valid   = r_s2_valid;
    assign bus.taken       = r_s2_taken;
    assign bus.mispredict  = r_s2_mispredict;
    assign bus.redirect_pc = r_s2_redirect;
    assign bus.illegal_op  = r_s2_illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
    u1  w_out_fire;
    u32 r_br_count;
    u32 r_mispred_count;

    assign w_out_fire = r_s2_valid && bus.out_ready;

    // Saturating statistics; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else if (w_out_fire) begin
            if (r_br_count != '1) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (r_s2_mispredict && (r_mispred_count != '1)) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;
`endif

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter WIDTH, default 64, operand/PC data width in bits (legal 32 or 64).
REQ-002 Parameter PC_STEP, default 4, fall-through increment added to pc.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers a branch.
REQ-006 in_ready  output  1  block accepts the branch this cycle.
REQ-007 op  input  3  branch_op_t: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
REQ-008 rs1, rs2  input  WIDTH  compare operands.
REQ-009 pc, imm  input  WIDTH  branch PC and sign-extended offset.
REQ-010 pred_taken  input  1  frontend prediction.
REQ-011 flush  input  1  kill all in-flight branches.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 taken, mispredict  output  1  resolved direction; taken != pred_taken.
REQ-015 redirect_pc  output  WIDTH  taken ? pc+imm : pc+PC_STEP.
REQ-016 illegal_op  output  1  op is 010 or 011.

Function
REQ-017 The block SHALL be a 2-stage elastic pipeline: S1 registers eq/lt/ltu flags, op, both candidate PCs and pred_taken; S2 registers taken, mispredict, redirect_pc, illegal_op.
REQ-018 Latency SHALL be exactly 2 cycles from input handshake (in_valid & in_ready) to out_valid with out_ready held high; throughput 1 per cycle.
REQ-019 S2 SHALL load when s2 empty or out_ready; S1 SHALL advance when S2 loads; in_ready SHALL equal !s1_valid | s1_advance (combinational, no dependence on in_valid).
REQ-020 With out_valid high and out_ready low, all outputs SHALL hold stable; no result is dropped or duplicated.
REQ-021 Signed compare SHALL use two's complement over WIDTH; unsigned compare SHALL use magnitude; eq on all WIDTH bits.
REQ-022 pc+imm and pc+PC_STEP SHALL wrap modulo 2^WIDTH, no overflow flag.
REQ-023 Illegal op SHALL resolve as not-taken, redirect_pc=pc+PC_STEP, illegal_op=1.
REQ-024 flush SHALL clear s1_valid and s2_valid next cycle; an input presented with flush is dropped; flush overrides simultaneous handshakes.

Reset
REQ-025 On reset both valids, taken, mispredict, illegal_op SHALL be 0, redirect_pc 0; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight branches identically to flush.

Configuration
REQ-027 With BRANCH_RESOLVE_STATS_EN defined: 32-bit outputs br_count and mispred_count SHALL increment on each output handshake (mispred_count only if mispredict), saturating at 0xFFFFFFFF, cleared by reset only (not flush).
REQ-028 Without BRANCH_RESOLVE_STATS_EN: those ports and counters SHALL not exist.

Structure
REQ-029 branch_op_t enum and PC_STEP default SHALL live in package pipes; u1/u32 from common.
REQ-030 One sub-module branch_cmp (parameter WIDTH; outputs eq, lt, ltu) SHALL be instantiated in S1.

Verification
REQ-031 BLT rs1=-1, rs2=1, pc=0x1000, imm=0x20, pred 0, out_ready=1 -> 2 cycles later taken=1, mispredict=1, redirect_pc=0x1020.
REQ-032 BLTU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> taken=0, redirect_pc=pc+4.
REQ-033 pc=0xFFFF_FFFF_FFFF_FFFC, imm=8, BEQ equal operands -> redirect_pc=0x4.
REQ-034 Back-to-back 4 branches, out_ready low 3 cycles after first result -> in_ready low once both stages full; all 4 results emerge in order, none lost.
REQ-035 flush in cycle after 2 handshakes -> no out_valid; op=010 -> illegal_op=1, taken=0.
REQ-036 With STATS_EN, 10 branches, 3 mispredicted -> br_count=10, mispred_count=3; preload near max -> saturates.
